// File: rtl/arbitro_mux3_if.sv
// Handshake bundle between the three requesters and the mux arbiter.
// slave: arbiter side (enable/req/bus_ready in; grant/controle/bus_valid/busy/beat_count out).
// master: requester/bus side, mirror of slave.
interface arbitro_mux3_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic [2:0]       req;
    logic             bus_ready;
    logic [2:0]       grant;
    logic [1:0]       controle;
    logic             bus_valid;
    logic             busy;
    logic [CNT_W-1:0] beat_count;

    modport master (
        output enable, req, bus_ready,
        input  grant, controle, bus_valid, busy, beat_count
    );

    modport slave (
        input  enable, req, bus_ready,
        output grant, controle, bus_valid, busy, beat_count
    );
endinterface

// File: rtl/arbitro_mux3.sv
// Round-robin arbiter/sequencer driving the select of a 3:1 32-bit mux.
// Ports: clock, reset (async active-low), bus (arbitro_mux3_if.slave).
module arbitro_mux3 #(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 8
) (
    input logic          clock,
    input logic          reset,
    arbitro_mux3_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_TURN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       ctl_q, ctl_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] c0, c1, c2, win;
    logic       own_req, beat;

    function automatic logic [1:0] succ(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

    // Search order starts just after the previous owner.
    always_comb begin
        c0 = succ(last_q);
        c1 = succ(c0);
        c2 = succ(c1);
        if (bus.req[c0])      win = c0;
        else if (bus.req[c1]) win = c1;
        else                  win = c2;
    end

    // Owner is always identified by the held select code.
    assign own_req = bus.req[ctl_q];
    assign beat    = (state_q == S_BUSY) & own_req & bus.bus_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= 3'b000;
            ctl_q   <= 2'b00;
            last_q  <= 2'd2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ctl_q   <= ctl_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ctl_d   = ctl_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.enable && (bus.req != 3'b000)) begin
                    state_d = S_BUSY;
                    grant_d = 3'b001 << win;
                    ctl_d   = win;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (beat) cnt_d = cnt_q + 1'b1;
                if (!own_req || (beat && cnt_q == LAST_BEAT)) begin
                    state_d = S_TURN;
                    grant_d = 3'b000;
                    last_d  = ctl_q;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.grant      = grant_q;
        bus.controle   = ctl_q;
        bus.beat_count = cnt_q;
        bus.busy       = (state_q == S_BUSY);
        bus.bus_valid  = (state_q == S_BUSY) & own_req;
    end
endmodule

// File: tb/tb_arbitro_mux3.sv
// Randomized bench for arbitro_mux3 against a transaction-level model.
// Includes mid-burst async reset pulses and enable toggling.
module tb_arbitro_mux3;
    localparam int MAXB  = 4;
    localparam int CNT_W = 8;

    logic clock = 1'b0;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    arbitro_mux3_if #(.CNT_W(CNT_W)) bus_if ();

    arbitro_mux3 #(
        .MAX_BEATS(MAXB),
        .CNT_W    (CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: 0 = no grant, 1 = owner holds bus, 2 = dead turnaround.
    int m_ph, m_own, m_cnt, m_last, m_sel;
    int n_ph, n_own, n_cnt, n_last, n_sel;

    task automatic model_reset();
        m_ph = 0; m_own = 0; m_cnt = 0;
        m_last = 2; m_sel = 0;
    endtask

    task automatic check_all(input string p);
        logic [2:0] eg;
        logic       ev;
        eg = (m_ph == 1) ? 3'(1 << m_own) : 3'b000;
        ev = (m_ph == 1) && bus_if.req[m_own];
        chk({p, "grant"},  32'(bus_if.grant), 32'(eg));
        chk({p, "ctl"},    32'(bus_if.controle), 32'(m_sel));
        chk({p, "valid"},  32'(bus_if.bus_valid), 32'(ev));
        chk({p, "busy"},   32'(bus_if.busy), 32'(m_ph == 1));
        chk({p, "cnt"},    32'(bus_if.beat_count), 32'(m_cnt));
        chk({p, "cntmax"},
            32'(bus_if.beat_count <= CNT_W'(MAXB)), 32'd1);
    endtask

    task automatic model_step();
        bit vld, bt, found;
        int idx;
        n_ph = m_ph; n_own = m_own; n_cnt = m_cnt;
        n_last = m_last; n_sel = m_sel;
        case (m_ph)
            0: if (bus_if.enable && bus_if.req != 3'b000) begin
                found = 0;
                for (int k = 1; k <= 3; k++) begin
                    idx = (m_last + k) % 3;
                    if (!found && bus_if.req[idx]) begin
                        found = 1;
                        n_own = idx;
                    end
                end
                n_ph = 1; n_cnt = 0; n_sel = n_own;
            end
            1: begin
                vld = bus_if.req[m_own];
                bt  = vld && bus_if.bus_ready;
                if (bt) n_cnt = m_cnt + 1;
                if (!vld || (bt && m_cnt + 1 == MAXB)) begin
                    n_ph = 2;
                    n_last = m_own;
                end
            end
            default: begin
                n_ph = 0; n_cnt = 0;
            end
        endcase
    endtask

    initial begin
        reset = 1'b0;
        bus_if.enable    = 1'b0;
        bus_if.req       = 3'b000;
        bus_if.bus_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check_all("rst_");
        reset = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            for (int b = 0; b < 3; b++)
                if ($urandom_range(7) == 0)
                    bus_if.req[b] = ~bus_if.req[b];
            bus_if.bus_ready = ($urandom_range(3) != 0);
            if (i % 64 < 8)
                bus_if.enable = 1'b0;
            else
                bus_if.enable = ($urandom_range(15) != 0);
            #1;
            check_all("cyc_");
            model_step();
            if (i % 300 == 150) begin
                #2 reset = 1'b0;
                #1;
                chk("arst_grant", 32'(bus_if.grant), 32'd0);
                chk("arst_valid", 32'(bus_if.bus_valid), 32'd0);
                chk("arst_cnt", 32'(bus_if.beat_count), 32'd0);
                chk("arst_busy", 32'(bus_if.busy), 32'd0);
                model_reset();
                @(posedge clock);
                #2 reset = 1'b1;
            end else begin
                @(posedge clock);
                m_ph = n_ph; m_own = n_own; m_cnt = n_cnt;
                m_last = n_last; m_sel = n_sel;
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/arbitro_mux3.md
Name: arbitro_mux3

Overview:
- Round-robin arbiter and sequencer for the shared three-input 32-bit datapath multiplexer.
- Three requesters compete for the single downstream bus behind the mux.
- The block grants one requester at a time and drives the mux select code (00/01/10).
- It holds the grant for a burst of beats, qualifies each beat with a valid/ready handshake, then rotates priority.

Parameters:
- MAX_BEATS, 4, maximum accepted beats per grant before forced release (legal range 1..255).
- CNT_W, 8, width of the beat counter and beat_count output.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new grant is issued; a grant already in progress completes normally.
- req  input  3  level request per requester; bit i maps to mux input i.
- bus_ready  input  1  downstream accepts the current beat.
- grant  output  3  one-hot grant, registered.
- controle  output  2  mux select, registered: 00, 01 or 10; never 11.
- bus_valid  output  1  beat valid toward downstream.
- busy  output  1  high in BUSY state.
- beat_count  output  CNT_W  beats accepted in the current grant.

Behaviour:
- Reset (async assert): state=IDLE, grant=000, controle=00, bus_valid=0, busy=0, beat_count=0, last=2.
  - With last=2, requester 0 has highest priority after reset.
  - Reset asserted mid-burst drops grant and bus_valid immediately; no release cycle occurs.
- FSM states: IDLE, BUSY, TURN.
- IDLE:
  - If enable=1 and req!=000: winner = first set bit searching last+1, last+2, last+3 (mod 3).
  - Next edge: grant=onehot(winner), controle=winner, beat_count=0, state=BUSY.
  - Latency from req asserted (sampled in IDLE) to grant is 1 cycle.
  - Otherwise stay in IDLE with outputs at their reset values, except controle, which holds its last value.
- BUSY (owner g):
  - bus_valid = req[g], combinational from req in this state; bus_valid=0 in all other states.
  - Beat = bus_valid & bus_ready. Each beat increments beat_count.
  - Release when req[g]=0, or when a beat is accepted while beat_count==MAX_BEATS-1.
  - On release, next edge: grant=000, last=g, state=TURN. beat_count holds its final value through TURN.
  - req[g] dropping in the same cycle as bus_ready=1 is not a beat (bus_valid=0); release still occurs.
  - Requests from non-owners are ignored while BUSY.
  - controle stays stable for the whole grant and through TURN.
- TURN: one dead cycle (grant=000, bus_valid=0) for mux turnaround. Next edge: state=IDLE, beat_count=0.
- Throughput: back-to-back grants are spaced by at least 2 idle cycles (TURN + IDLE).
- Fairness: a continuously requesting requester waits at most 2 other grants.
- MAX_BEATS=1: every accepted beat forces release.
- beat_count never exceeds MAX_BEATS.
- Toggling enable has no effect while BUSY or TURN.

Test Plan:
1. Reset release, req=001, bus_ready=1 -> grant=001 and controle=00 one cycle later; 4 beats; grant drops after the 4th beat; TURN; beat_count reads 4 during TURN.
2. req=111 held, bus_ready=1, MAX_BEATS=4 -> grant sequence 001, 010, 100, 001, each for 4 beats, separated by 2 cycles with grant=000; controle follows 00, 01, 10, 00.
3. Grant to req1 with bus_ready toggling 1,0,1,0,1,1 -> beat_count advances only on cycles where ready=1; release after the 4th accepted beat.
4. Owner req2 drops in the same cycle bus_ready=1 after 2 beats -> no 3rd beat counted, beat_count=2, release, last=2; next grant goes to requester 0 if it requests.
5. enable=0 with req=010 -> grant stays 000 indefinitely; set enable=1 -> grant=010 on the next edge. Deassert enable mid-burst -> the burst completes.
6. Assert reset mid-burst (grant=100, beat_count=2) -> grant=000, bus_valid=0, beat_count=0 asynchronously; after release with req=100, grant goes to requester 2 (last=2 restored, so requester 2 is searched last but is the only requester).
